// File: rtl/cr_tlvp2_split_core.sv
// Inbound TLV splitter: steers whole TLVs from the ingress FIFO to the user-engine or passthrough FIFO.
// Optional header BIP2 check is compiled in with `define CR_TLVP_SPLIT_BIP2_CHK_EN.
package cr_tlvp2_split_pkg;

    typedef struct packed {
        logic [63:0] tdata;
        logic [7:0]  tuser;
        logic [7:0]  tid;
        logic [7:0]  tstrb;
        logic        tlast;
    } axi4s_dp_bus_t;

    // ordern/typen are carried zero-extended in 8-bit fields
    typedef struct packed {
        logic [63:0] tdata;
        logic [7:0]  tuser;
        logic [7:0]  tid;
        logic [7:0]  tstrb;
        logic        tlast;
        logic        insert;
        logic [7:0]  ordern;
        logic [7:0]  typen;
        logic        sot;
        logic        eot;
    } tlvp_if_bus_t;

endpackage

module cr_tlvp2_split_core
    import cr_tlvp2_split_pkg::*;
#(
    parameter int TYP_W = 5,
    parameter int ORD_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tlvp_ib_empty,
    input  axi4s_dp_bus_t           tlvp_ib_rdata,
    output logic                    tlvp_split_ib_rd,
    input  logic [(1<<TYP_W)-1:0]   usr_type_mask,
    input  logic                    pt_ib_afull,
    input  logic                    usr_ib_afull,
    output logic                    pt_ib_wen,
    output logic                    usr_ib_wen,
    output tlvp_if_bus_t            pt_ib_tlv,
    output tlvp_if_bus_t            usr_ib_tlv,
    output logic                    split_err_trunc,
    output logic                    split_err_len,
    output logic                    split_err_bip2
);

    typedef enum logic {ST_HDR, ST_BODY} state_t;

    state_t           r_state, w_state_next;
    logic [15:0]      r_rem, w_rem_next;
    logic [ORD_W-1:0] r_ord_cnt, w_ord_cnt_next;
    logic [ORD_W-1:0] r_ordern, w_ordern;
    logic [TYP_W-1:0] r_typen, w_typen;
    logic             r_route, w_route;

    logic             r_pt_wen, r_usr_wen;
    tlvp_if_bus_t     r_tlv, w_tlv_next;
    logic             r_err_trunc, r_err_len;

    axi4s_dp_bus_t    w_word;
    logic             w_pop;
    logic             w_is_hdr;
    logic [15:0]      w_len;
    logic [15:0]      w_hdr_rem;
    logic             w_bip_bad;
    logic             w_sot, w_eot, w_trunc, w_len_err;

    assign w_word    = tlvp_ib_rdata;
    assign w_pop     = ~tlvp_ib_empty & ~pt_ib_afull & ~usr_ib_afull;
    assign w_is_hdr  = (r_state == ST_HDR) | w_word.tuser[0];
    assign w_len     = w_word.tdata[31:16];
    assign w_hdr_rem = (w_len == 16'd0) ? 16'd0 : w_len - 16'd1;

    assign tlvp_split_ib_rd = w_pop;

`ifdef CR_TLVP_SPLIT_BIP2_CHK_EN
    localparam logic [61:0] BIP_EVEN_MASK = {31{2'b01}};
    localparam logic [61:0] BIP_ODD_MASK  = {31{2'b10}};

    logic [1:0] w_bip_calc;
    logic       r_err_bip2;

    assign w_bip_calc = {^(w_word.tdata[61:0] & BIP_ODD_MASK),
                         ^(w_word.tdata[61:0] & BIP_EVEN_MASK)};
    assign w_bip_bad  = (w_bip_calc != w_word.tdata[63:62]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_bip2 <= 1'b0;
        end else begin
            r_err_bip2 <= w_pop & w_is_hdr & w_bip_bad;
        end
    end

    assign split_err_bip2 = r_err_bip2;
`else
    assign w_bip_bad      = 1'b0;
    assign split_err_bip2 = 1'b0;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_rem_next     = r_rem;
        w_ord_cnt_next = r_ord_cnt;
        w_ordern       = r_ordern;
        w_typen        = r_typen;
        w_route        = r_route;
        w_sot          = 1'b0;
        w_eot          = 1'b0;
        w_trunc        = 1'b0;
        w_len_err      = 1'b0;
        if (w_pop) begin
            if (w_is_hdr) begin
                w_typen        = w_word.tdata[TYP_W-1:0];
                w_route        = usr_type_mask[w_typen] & ~w_bip_bad;
                w_ordern       = w_word.tuser[0] ? ORD_W'(1) : r_ord_cnt;
                w_ord_cnt_next = w_ordern + ORD_W'(1);
                w_sot          = 1'b1;
                // a frame start arriving mid-TLV abandons the previous TLV
                w_trunc        = (r_state == ST_BODY);
                w_len_err      = (w_len == 16'd0);
                if ((w_hdr_rem == 16'd0) || w_word.tlast) begin
                    w_eot        = 1'b1;
                    w_state_next = ST_HDR;
                    w_rem_next   = 16'd0;
                    if (w_word.tlast && (w_hdr_rem != 16'd0)) begin
                        w_trunc   = 1'b1;
                        w_len_err = 1'b1;
                    end
                end else begin
                    w_state_next = ST_BODY;
                    w_rem_next   = w_hdr_rem;
                end
            end else begin
                w_rem_next = r_rem - 16'd1;
                if ((r_rem == 16'd1) || w_word.tlast) begin
                    w_eot        = 1'b1;
                    w_state_next = ST_HDR;
                    w_rem_next   = 16'd0;
                    if (w_word.tlast && (r_rem > 16'd1)) begin
                        w_trunc   = 1'b1;
                        w_len_err = 1'b1;
                    end
                end
            end
            if (w_word.tlast) begin
                w_ord_cnt_next = ORD_W'(1);
            end
        end
    end

    always_comb begin
        w_tlv_next        = '0;
        w_tlv_next.tdata  = w_word.tdata;
        w_tlv_next.tuser  = w_word.tuser;
        w_tlv_next.tid    = w_word.tid;
        w_tlv_next.tstrb  = w_word.tstrb;
        w_tlv_next.tlast  = w_word.tlast;
        w_tlv_next.insert = 1'b0;
        w_tlv_next.ordern = 8'(w_ordern);
        w_tlv_next.typen  = 8'(w_typen);
        w_tlv_next.sot    = w_sot;
        w_tlv_next.eot    = w_eot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_HDR;
            r_rem       <= 16'd0;
            r_ord_cnt   <= ORD_W'(1);
            r_ordern    <= '0;
            r_typen     <= '0;
            r_route     <= 1'b0;
            r_pt_wen    <= 1'b0;
            r_usr_wen   <= 1'b0;
            r_tlv       <= '0;
            r_err_trunc <= 1'b0;
            r_err_len   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rem       <= w_rem_next;
            r_ord_cnt   <= w_ord_cnt_next;
            r_ordern    <= w_ordern;
            r_typen     <= w_typen;
            r_route     <= w_route;
            r_pt_wen    <= w_pop & ~w_route;
            r_usr_wen   <= w_pop & w_route;
            r_err_trunc <= w_pop & w_trunc;
            r_err_len   <= w_pop & w_len_err;
            if (w_pop) begin
                r_tlv <= w_tlv_next;
            end
        end
    end

    // both destinations see the same word; the write strobe selects the owner
    assign pt_ib_wen       = r_pt_wen;
    assign usr_ib_wen      = r_usr_wen;
    assign pt_ib_tlv       = r_tlv;
    assign usr_ib_tlv      = r_tlv;
    assign split_err_trunc = r_err_trunc;
    assign split_err_len   = r_err_len;

endmodule

// File: tb/tb_cr_tlvp2_split_core.sv
// Randomized bench for cr_tlvp2_split_core: TLV frames are built from type/length/truncation
// choices and the expected output words are derived directly from those choices.
module tb_cr_tlvp2_split_core;
    import cr_tlvp2_split_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tlvp_ib_empty;
    axi4s_dp_bus_t tlvp_ib_rdata;
    logic          tlvp_split_ib_rd;
    logic [31:0]   usr_type_mask;
    logic          pt_ib_afull, usr_ib_afull;
    logic          pt_ib_wen, usr_ib_wen;
    tlvp_if_bus_t  pt_ib_tlv, usr_ib_tlv;
    logic          split_err_trunc, split_err_len, split_err_bip2;

    cr_tlvp2_split_core #(.TYP_W(5), .ORD_W(5)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tlvp_ib_empty    (tlvp_ib_empty),
        .tlvp_ib_rdata    (tlvp_ib_rdata),
        .tlvp_split_ib_rd (tlvp_split_ib_rd),
        .usr_type_mask    (usr_type_mask),
        .pt_ib_afull      (pt_ib_afull),
        .usr_ib_afull     (usr_ib_afull),
        .pt_ib_wen        (pt_ib_wen),
        .usr_ib_wen       (usr_ib_wen),
        .pt_ib_tlv        (pt_ib_tlv),
        .usr_ib_tlv       (usr_ib_tlv),
        .split_err_trunc  (split_err_trunc),
        .split_err_len    (split_err_len),
        .split_err_bip2   (split_err_bip2)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           route;
        tlvp_if_bus_t tlv;
        logic [2:0]   errs;
    } exp_t;

    axi4s_dp_bus_t q_in[$];
    exp_t          q_exp[$];
    bit            prev_mid;
    bit            last_pop;
    bit            have_last;
    bit            last_route;
    tlvp_if_bus_t  last_tlv;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] bip2(input logic [61:0] x);
        logic [1:0] b = 2'b00;
        for (int k = 0; k < 62; k++) b[k % 2] = b[k % 2] ^ x[k];
        return b;
    endfunction

    // One TLV: idx is its 1-based position in the frame, nw the words actually sent.
    task automatic add_tlv(input int typ, input int len, input int nw, input bit sof,
                           input bit tl, input int idx, input bit bad_bip);
        int            full_len;
        bit            route;
        axi4s_dp_bus_t w;
        exp_t          e;
        logic [63:0]   d;
        bit            last_w, tl_w;
        full_len = (len == 0) ? 1 : len;
`ifdef CR_TLVP_SPLIT_BIP2_CHK_EN
        route = usr_type_mask[typ] && !bad_bip;
`else
        route = usr_type_mask[typ];
`endif
        for (int j = 0; j < nw; j++) begin
            d = {$urandom, $urandom};
            if (j == 0) begin
                d[31:16] = len[15:0];
                d[4:0]   = typ[4:0];
                d[63:62] = bip2(d[61:0]) ^ (bad_bip ? 2'b01 : 2'b00);
            end
            last_w     = (j == nw - 1);
            tl_w       = tl && last_w;
            w.tdata    = d;
            w.tuser    = 8'($urandom);
            w.tuser[0] = (j == 0) && sof;
            w.tid      = 8'($urandom);
            w.tstrb    = 8'($urandom);
            w.tlast    = tl_w;
            e.route    = route;
            e.tlv.tdata  = w.tdata;
            e.tlv.tuser  = w.tuser;
            e.tlv.tid    = w.tid;
            e.tlv.tstrb  = w.tstrb;
            e.tlv.tlast  = w.tlast;
            e.tlv.insert = 1'b0;
            e.tlv.ordern = 8'(idx % 32);
            e.tlv.typen  = 8'(typ);
            e.tlv.sot    = (j == 0);
            e.tlv.eot    = last_w && ((nw == full_len) || tl);
            e.errs[2]    = (tl_w && (j < full_len - 1)) || ((j == 0) && sof && prev_mid);
            e.errs[1]    = ((j == 0) && (len == 0)) || (tl_w && (j < full_len - 1));
`ifdef CR_TLVP_SPLIT_BIP2_CHK_EN
            e.errs[0]    = (j == 0) && bad_bip;
`else
            e.errs[0]    = 1'b0;
`endif
            q_in.push_back(w);
            q_exp.push_back(e);
        end
        prev_mid = (nw < full_len) && !tl;
    endtask

    task automatic gen_frame();
        int n, mode, typ, len, full_len, nw;
        bit tl;
        n    = $urandom_range(1, 6);
        mode = $urandom_range(0, 2);
        for (int i = 1; i <= n; i++) begin
            typ      = $urandom_range(0, 31);
            len      = $urandom_range(0, 5);
            full_len = (len == 0) ? 1 : len;
            nw       = full_len;
            tl       = 1'b0;
            if (i == n) begin
                if (mode != 0) nw = $urandom_range(1, full_len);
                tl = (mode != 2);
            end
            add_tlv(typ, len, nw, i == 1, tl, i, $urandom_range(0, 7) == 0);
        end
    endtask

    // af_mode: 0 none, 1 random afull on both, 2 pt_ib_afull toggles every 4 cycles
    task automatic run(input int stall_pct, input int af_mode);
        int   cyc = 0;
        exp_t e;
        bit   exp_rd;
        while ((q_in.size() != 0 || last_pop) && cyc < 4000) begin
            @(posedge clk);
            #1;
            if (last_pop) begin
                if (q_exp.size() == 0) begin
                    check("spurious_pop", 1, 0);
                end else begin
                    e = q_exp.pop_front();
                    void'(q_in.pop_front());
                    check("wen", 128'({pt_ib_wen, usr_ib_wen}), e.route ? 128'(2'b01) : 128'(2'b10));
                    check("tlv", e.route ? 128'(usr_ib_tlv) : 128'(pt_ib_tlv), 128'(e.tlv));
                    check("errs", 128'({split_err_trunc, split_err_len, split_err_bip2}), 128'(e.errs));
                    $display("word ord=%0d typ=%0d sot=%0d eot=%0d usr=%0d errs=%b",
                             e.tlv.ordern, e.tlv.typen, e.tlv.sot, e.tlv.eot, e.route, e.errs);
                    have_last  = 1'b1;
                    last_route = e.route;
                    last_tlv   = e.tlv;
                end
            end else begin
                check("idle", 128'({pt_ib_wen, usr_ib_wen, split_err_trunc, split_err_len, split_err_bip2}), 0);
                if (have_last)
                    check("hold", last_route ? 128'(usr_ib_tlv) : 128'(pt_ib_tlv), 128'(last_tlv));
            end
            tlvp_ib_empty = (q_in.size() == 0) || ($urandom_range(0, 99) < stall_pct);
            tlvp_ib_rdata = (q_in.size() != 0) ? q_in[0] : axi4s_dp_bus_t'({$urandom, $urandom, $urandom, $urandom});
            case (af_mode)
                1: begin
                    pt_ib_afull  = ($urandom_range(0, 9) == 0);
                    usr_ib_afull = ($urandom_range(0, 9) == 0);
                end
                2: begin
                    pt_ib_afull  = ((cyc / 4) % 2) == 1;
                    usr_ib_afull = 1'b0;
                end
                default: begin
                    pt_ib_afull  = 1'b0;
                    usr_ib_afull = 1'b0;
                end
            endcase
            #1;
            exp_rd = !tlvp_ib_empty && !pt_ib_afull && !usr_ib_afull;
            check("rd", 128'(tlvp_split_ib_rd), 128'(exp_rd));
            last_pop = tlvp_split_ib_rd;
            cyc++;
        end
        check("drain_timeout", 128'(cyc >= 4000), 0);
        check("drain_left", 128'(q_exp.size()), 0);
        q_in.delete();
        q_exp.delete();
        last_pop      = 1'b0;
        tlvp_ib_empty = 1'b1;
        pt_ib_afull   = 1'b0;
        usr_ib_afull  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wen"}, 128'({pt_ib_wen, usr_ib_wen}), 0);
        check({tag, "_err"}, 128'({split_err_trunc, split_err_len, split_err_bip2}), 0);
        check({tag, "_pt_tlv"}, 128'(pt_ib_tlv), 0);
        check({tag, "_usr_tlv"}, 128'(usr_ib_tlv), 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        tlvp_ib_empty = 1'b1;
        tlvp_ib_rdata = '0;
        pt_ib_afull   = 1'b0;
        usr_ib_afull  = 1'b0;
        usr_type_mask = '0;
        prev_mid      = 1'b0;
        last_pop      = 1'b0;
        have_last     = 1'b0;
        last_route    = 1'b0;
        last_tlv      = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // three TLVs, type 3 to user; next frame's first header restarts at 1
        usr_type_mask = 32'h0000_0008;
        add_tlv(1, 2, 2, 1, 0, 1, 0);
        add_tlv(3, 1, 1, 0, 0, 2, 0);
        add_tlv(1, 3, 3, 0, 1, 3, 0);
        add_tlv(2, 1, 1, 1, 1, 1, 0);
        run(0, 0);

        // tlast on the 2nd word of a len-4 TLV
        add_tlv(2, 4, 2, 1, 1, 1, 0);
        run(0, 0);

        // len==0 header followed by a normal TLV
        add_tlv(0, 0, 1, 1, 0, 1, 0);
        add_tlv(4, 2, 2, 0, 1, 2, 0);
        run(0, 0);

        // random frames with ingress stalls and random backpressure
        usr_type_mask = {$urandom};
        for (int f = 0; f < 30; f++) gen_frame();
        run(20, 1);

        // ingress always full, pt_ib_afull toggling every 4 cycles
        usr_type_mask = {$urandom};
        for (int f = 0; f < 10; f++) gen_frame();
        run(0, 2);

        // 33 single-word TLVs in one frame: ordern wraps 31 -> 0 -> 1
        for (int i = 1; i <= 33; i++) add_tlv($urandom_range(0, 31), 1, 1, i == 1, i == 33, i, 0);
        run(0, 0);

        // corrupted BIP2 on a user-masked header
        usr_type_mask = 32'h0000_0008;
        add_tlv(3, 2, 2, 1, 1, 1, 1);
        run(0, 0);

        // reset mid-TLV, then a header without frame start must still parse with ordern 1
        add_tlv(5, 4, 2, 1, 0, 1, 0);
        run(0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        prev_mid  = 1'b0;
        have_last = 1'b0;
        add_tlv(7, 1, 1, 0, 1, 1, 0);
        add_tlv(9, 3, 3, 0, 1, 1, 0);
        run(0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
